// File: rtl/rng_arbiter.sv
// rtl/rng_arbiter.sv - prefetch FIFO and round-robin sharing of one MT19937 generator
module rng_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DEPTH   = 8,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    output logic               rng_start,
    input  logic               rng_valid,
    input  logic [31:0]        rng_data,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [31:0]        rand_out,
    output logic               rand_valid,
    output logic [AW:0]        fill
);

    localparam int          RW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic {
        ST_WAIT  = 1'b0,
        ST_BLANK = 1'b1
    } fetch_e;

    fetch_e             state_q;
    logic [31:0]        mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        fill_q;
    logic [AW:0]        fill_d;
    logic [RW-1:0]      rr_q;
    logic [RW-1:0]      rr_d;
    logic [RW-1:0]      gidx_d;
    logic [RW-1:0]      cand;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] gnt_d;
    logic [31:0]        rand_out_q;
    logic               rand_valid_q;
    logic               rng_start_q;
    logic               found_d;
    logic               push_d;
    logic               pop_d;
    int                 scan_idx;

    // Round-robin scan starting at rr_q; grant only against occupancy before any same-edge push.
    always_comb begin
        found_d  = 1'b0;
        gidx_d   = '0;
        cand     = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(rr_q) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            cand = RW'(scan_idx);
            if (!found_d && req[cand]) begin
                found_d = 1'b1;
                gidx_d  = cand;
            end
        end

        pop_d = found_d && (fill_q != '0);

        gnt_d = '0;
        if (pop_d) begin
            gnt_d[gidx_d] = 1'b1;
        end

        rr_d = rr_q;
        if (pop_d) begin
            rr_d = (gidx_d == RW'(NUM_REQ - 1)) ? '0 : gidx_d + 1'b1;
        end

        // A full FIFO leaves the word parked in the generator with valid still high.
        push_d = (state_q == ST_WAIT) && rng_valid && (fill_q != FULL);

        fill_d = fill_q;
        if (push_d && !pop_d) begin
            fill_d = fill_q + 1'b1;
        end else if (!push_d && pop_d) begin
            fill_d = fill_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_d) begin
            mem_q[wr_ptr_q] <= rng_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_WAIT;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            rr_q         <= '0;
            gnt_q        <= '0;
            rand_out_q   <= '0;
            rand_valid_q <= 1'b0;
            rng_start_q  <= 1'b0;
        end else begin
            // BLANK covers the edge where the generator still shows the old valid.
            case (state_q)
                ST_WAIT:  state_q <= push_d ? ST_BLANK : ST_WAIT;
                ST_BLANK: state_q <= ST_WAIT;
                default:  state_q <= ST_WAIT;
            endcase
            rng_start_q <= push_d;
            if (push_d) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_d) begin
                rd_ptr_q   <= rd_ptr_q + 1'b1;
                rand_out_q <= mem_q[rd_ptr_q];
            end
            fill_q       <= fill_d;
            rr_q         <= rr_d;
            gnt_q        <= gnt_d;
            rand_valid_q <= pop_d;
        end
    end

    assign rng_start  = rng_start_q;
    assign gnt        = gnt_q;
    assign rand_out   = rand_out_q;
    assign rand_valid = rand_valid_q;
    assign fill       = fill_q;

endmodule
